// File: rtl/mem_req_ctrl_if.sv
// Data-memory bus for mem_req_ctrl: the controller is the master, the multi-cycle memory is the slave.
interface mem_req_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;

    modport master (
        output mem_addr, mem_data_in, mem_rd, mem_wr,
        input  mem_data_out, mem_done, mem_stall, mem_err
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_rd, mem_wr,
        output mem_data_out, mem_done, mem_stall, mem_err
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Load/store request controller between execute and a multi-cycle data memory (Done/Stall handshake).
// Define MEM_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles with a sticky error.
module mem_req_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              flush,
    input  logic [ADDR_W-1:0] XOut,
    input  logic [DATA_W-1:0] WriteData,
    mem_req_ctrl_if.master    mem,
    output logic              Stall,
    output logic [DATA_W-1:0] MemOut,
    output logic              MemValid,
    output logic              err
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("mem_req_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_load_q, is_load_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              req;
    logic              bad;

    assign req = (MemRead ^ MemWrite) & ~XOut[0] & ~flush;
    assign bad = (MemRead & MemWrite) | ((MemRead | MemWrite) & XOut[0]);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;
`endif

    always_comb begin
        // NOTE: every output and every _d gets a default first, so no branch can infer a latch.
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        is_load_d       = is_load_q;
        rdata_d         = rdata_q;
        drop_d          = drop_q;
        err_d           = err_q | mem.mem_err | bad;
        Stall           = 1'b0;
        MemValid        = 1'b0;
        MemOut          = '0;
        mem.mem_rd      = 1'b0;
        mem.mem_wr      = 1'b0;
        mem.mem_addr    = addr_q;
        mem.mem_data_in = wdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                mem.mem_addr    = XOut;
                mem.mem_data_in = WriteData;
                mem.mem_rd      = MemRead & req;
                mem.mem_wr      = MemWrite & req;
                if (req) begin
                    if (mem.mem_done) begin
                        MemValid = MemRead;
                        MemOut   = MemRead ? mem.mem_data_out : '0;
                    end else if (mem.mem_stall) begin
                        // Not accepted: upstream keeps the request up and it is reissued next cycle.
                        Stall = 1'b1;
                    end else begin
                        Stall     = 1'b1;
                        addr_d    = XOut;
                        wdata_d   = WriteData;
                        is_load_d = MemRead;
                        state_d   = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end

            S_WAIT: begin
                Stall = 1'b1;
                // An issued access is never cancelled; a flush only discards its result.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (mem.mem_done) begin
                    rdata_d = mem.mem_data_out;
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        Stall   = 1'b0;
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
`endif
            end

            S_DONE: begin
                MemValid = is_load_q & ~drop_q;
                MemOut   = (is_load_q & ~drop_q) ? rdata_q : '0;
                drop_d   = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs stay quiet for the whole time reset is held, not just after the first edge.
        if (rst) begin
            Stall           = 1'b0;
            MemValid        = 1'b0;
            MemOut          = '0;
            mem.mem_rd      = 1'b0;
            mem.mem_wr      = 1'b0;
            mem.mem_addr    = '0;
            mem.mem_data_in = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_load_q <= 1'b0;
            rdata_q   <= '0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus randomized transactions against
// a transaction-level model (stall length, strobe count and result derived from the request plan).
module tb_mem_req_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemRead, MemWrite, flush;
  logic [AW-1:0] XOut;
  logic [DW-1:0] WriteData;
  logic          Stall, MemValid, err;
  logic [DW-1:0] MemOut;
  int            total = 0;
  int            bad = 0;

  mem_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .flush(flush),
    .XOut(XOut), .WriteData(WriteData), .mem(mif),
    .Stall(Stall), .MemOut(MemOut), .MemValid(MemValid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; flush = 1'b0;
    XOut = '0; WriteData = '0;
    mif.mem_data_out = '0; mif.mem_done = 1'b0; mif.mem_stall = 1'b0; mif.mem_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Plays one request as upstream and memory: stall_n rejections, then acceptance, then mem_done
  // lat cycles later (lat=0 is a hit). Upstream scrambles XOut/WriteData during WAIT.
  task automatic drive_txn(
      input  logic ld, input logic [AW-1:0] a, input logic [DW-1:0] wd,
      input  int stall_n, input int lat, input int flush_at, input logic [DW-1:0] rd,
      output int n_stall, output int n_rd, output int n_wr,
      output logic v, output logic [DW-1:0] o, output int n_proto, output logic hung);
    n_stall = 0; n_rd = 0; n_wr = 0; n_proto = 0; v = 1'b0; o = '0; hung = 1'b1;
    MemRead = ld; MemWrite = ~ld;
    for (int k = 0; k < 200; k++) begin
      mif.mem_stall    = (k < stall_n);
      mif.mem_done     = (k == stall_n + lat);
      mif.mem_data_out = (k == stall_n + lat) ? rd : DW'($urandom);
      flush            = (flush_at > 0) && (k == stall_n + flush_at);
      if (k > stall_n && k <= stall_n + lat) begin
        XOut = AW'($urandom) & ~AW'(1);
        WriteData = DW'($urandom);
      end else begin
        XOut = a;
        WriteData = wd;
      end
      @(negedge clk);
      if (Stall) n_stall++;
      if (mif.mem_rd) n_rd++;
      if (mif.mem_wr) n_wr++;
      if (mif.mem_addr !== a || mif.mem_data_in !== wd) n_proto++;
      if (Stall && (MemValid !== 1'b0 || MemOut !== '0)) n_proto++;
      if (!Stall) begin
        v = MemValid; o = MemOut; hung = 1'b0;
      end
      step();
      if (!hung) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    MemRead = 1'b1; XOut = 16'h0010; mif.mem_done = 1'b1; mif.mem_data_out = 16'hBEEF;
    @(negedge clk);
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Stall); end
    total++; if (mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", mif.mem_rd, mif.mem_wr); end
    total++; if (MemValid !== 1'b0 || MemOut !== '0) begin bad++; $display("FAIL reset_memout got=%b/%h want=0/0000", MemValid, MemOut); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    @(negedge clk);
    total++; if (Stall !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_reset got stall=%b err=%b want 0/0", Stall, err); end
    step();
  endtask

  task automatic test_hit_load();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    drive_txn(1'b1, 16'h0010, 16'h0000, 0, 0, 0, 16'hBEEF, ns, nr, nw, v, o, np, h);
    total++; if (h !== 1'b0 || ns != 0) begin bad++; $display("FAIL hit_stall got=%0d hung=%b want=0", ns, h); end
    total++; if (nr != 1 || nw != 0) begin bad++; $display("FAIL hit_strobes got rd=%0d wr=%0d want 1/0", nr, nw); end
    total++; if (v !== 1'b1 || o !== 16'hBEEF) begin bad++; $display("FAIL hit_data got=%b/%h want=1/beef", v, o); end
  endtask

  task automatic test_miss_store();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    drive_txn(1'b0, 16'h0020, 16'h1234, 0, 4, 0, 16'hCAFE, ns, nr, nw, v, o, np, h);
    total++; if (h !== 1'b0 || ns != 5) begin bad++; $display("FAIL miss_stall got=%0d hung=%b want=5", ns, h); end
    total++; if (nw != 1 || nr != 0) begin bad++; $display("FAIL miss_strobes got rd=%0d wr=%0d want 0/1", nr, nw); end
    total++; if (v !== 1'b0 || o !== '0) begin bad++; $display("FAIL miss_done got=%b/%h want=0/0000", v, o); end
    total++; if (np != 0) begin bad++; $display("FAIL miss_hold got=%0d bad cycles want=0", np); end
  endtask

  task automatic test_busy_retry();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    drive_txn(1'b1, 16'h0100, 16'h0000, 2, 3, 0, 16'h7E57, ns, nr, nw, v, o, np, h);
    total++; if (nr != 3 || nw != 0) begin bad++; $display("FAIL retry_strobes got rd=%0d wr=%0d want 3/0", nr, nw); end
    total++; if (h !== 1'b0 || ns != 6) begin bad++; $display("FAIL retry_stall got=%0d want=6", ns); end
    total++; if (v !== 1'b1 || o !== 16'h7E57) begin bad++; $display("FAIL retry_data got=%b/%h want=1/7e57", v, o); end
  endtask

  task automatic test_flush_mid_miss();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    drive_txn(1'b1, 16'h0040, 16'h0000, 0, 5, 2, 16'hD00D, ns, nr, nw, v, o, np, h);
    total++; if (h !== 1'b0 || ns != 6) begin bad++; $display("FAIL flush_stall got=%0d want=6", ns); end
    total++; if (v !== 1'b0 || o !== '0) begin bad++; $display("FAIL flush_drop got=%b/%h want=0/0000", v, o); end
    drive_txn(1'b1, 16'h0042, 16'h0000, 0, 2, 0, 16'h1357, ns, nr, nw, v, o, np, h);
    total++; if (v !== 1'b1 || o !== 16'h1357) begin bad++; $display("FAIL flush_cleared got=%b/%h want=1/1357", v, o); end
  endtask

  task automatic test_idle_ignore();
    idle_inputs();
    MemRead = 1'b1; XOut = 16'h0010; flush = 1'b1; mif.mem_done = 1'b1; mif.mem_data_out = 16'hAAAA;
    @(negedge clk);
    total++; if (mif.mem_rd !== 1'b0 || Stall !== 1'b0 || MemValid !== 1'b0 || MemOut !== '0) begin
      bad++; $display("FAIL flush_idle got rd=%b stall=%b valid=%b out=%h want 0/0/0/0000", mif.mem_rd, Stall, MemValid, MemOut);
    end
    step();
    idle_inputs();
    mif.mem_done = 1'b1; mif.mem_data_out = 16'h5555;
    @(negedge clk);
    total++; if (Stall !== 1'b0 || MemValid !== 1'b0 || MemOut !== '0) begin
      bad++; $display("FAIL idle_done got stall=%b valid=%b out=%h want 0/0/0000", Stall, MemValid, MemOut);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_bad_request();
    for (int c = 0; c < 2; c++) begin
      do_reset();
      MemRead = 1'b1;
      MemWrite = (c == 1);
      XOut = (c == 0) ? 16'h0011 : 16'h0010;
      mif.mem_done = 1'b1; mif.mem_data_out = 16'h9999;
      @(negedge clk);
      total++; if (mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0 || Stall !== 1'b0 || MemValid !== 1'b0) begin
        bad++; $display("FAIL bad%0d_issue got rd=%b wr=%b stall=%b valid=%b want all 0", c, mif.mem_rd, mif.mem_wr, Stall, MemValid);
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL bad%0d_err_early got=%b want=0", c, err); end
      step();
      idle_inputs();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL bad%0d_err got=%b want=1", c, err); end
      step(); step();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL bad%0d_sticky got=%b want=1", c, err); end
    end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b want=0", err); end
  endtask

  task automatic test_mem_err();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    idle_inputs();
    mif.mem_err = 1'b1;
    step();
    mif.mem_err = 1'b0;
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL memerr_sticky got=%b want=1", err); end
    drive_txn(1'b1, 16'h0200, 16'h0000, 0, 2, 0, 16'h2468, ns, nr, nw, v, o, np, h);
    total++; if (ns != 3 || v !== 1'b1 || o !== 16'h2468) begin
      bad++; $display("FAIL memerr_proceed got stall=%0d valid=%b out=%h want 3/1/2468", ns, v, o);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    idle_inputs();
    MemRead = 1'b1; XOut = 16'h0030; WriteData = 16'h0000;
    step(); step(); step();
    @(negedge clk);
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL midwait_stall got=%b want=1", Stall); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (Stall !== 1'b0 || mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0 || MemValid !== 1'b0 || MemOut !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL midwait_reset got stall=%b rd=%b wr=%b valid=%b out=%h err=%b want all 0", Stall, mif.mem_rd, mif.mem_wr, MemValid, MemOut, err);
    end
    total++; if (mif.mem_addr !== '0 || mif.mem_data_in !== '0) begin
      bad++; $display("FAIL midwait_bus got addr=%h data=%h want 0000/0000", mif.mem_addr, mif.mem_data_in);
    end
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    drive_txn(1'b1, 16'h0032, 16'h0000, 0, 0, 0, 16'h5A5A, ns, nr, nw, v, o, np, h);
    total++; if (ns != 0 || v !== 1'b1 || o !== 16'h5A5A) begin
      bad++; $display("FAIL midwait_idle got stall=%0d valid=%b out=%h want 0/1/5a5a", ns, v, o);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int ns = 0; logic seen = 1'b0; logic v = 1'b1;
    idle_inputs();
    MemRead = 1'b1; XOut = 16'h0050;
    for (int k = 0; k < 4 * TO && !seen; k++) begin
      @(negedge clk);
      if (Stall) ns++;
      else begin seen = 1'b1; v = MemValid; end
      step();
    end
    idle_inputs();
    total++; if (seen !== 1'b1 || ns != TO) begin bad++; $display("FAIL timeout_stall got=%0d seen=%b want=%0d", ns, seen, TO); end
    total++; if (v !== 1'b0) begin bad++; $display("FAIL timeout_valid got=%b want=0", v); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", err); end
    @(negedge clk);
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", Stall); end
    step();
    do_reset();
  endtask
`endif

  task automatic test_random();
    int ns, nr, nw, np; logic v, h; logic [DW-1:0] o;
    for (int t = 0; t < 40; t++) begin
      logic          ld;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rd, exp_o;
      int            sn, lat, fa, exp_stall, exp_issue;
      logic          exp_v;
      ld  = 1'($urandom);
      a   = AW'($urandom) & ~AW'(1);
      wd  = DW'($urandom);
      rd  = DW'($urandom);
      sn  = $urandom_range(0, 2);
      lat = $urandom_range(0, 5);
      fa  = (lat > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      exp_stall = sn + ((lat == 0) ? 0 : lat + 1);
      exp_issue = sn + 1;
      exp_v     = ld && (fa == 0);
      exp_o     = exp_v ? rd : '0;
      drive_txn(ld, a, wd, sn, lat, fa, rd, ns, nr, nw, v, o, np, h);
      total++; if (h !== 1'b0) begin bad++; $display("FAIL rnd%0d_hung got=%b want=0", t, h); end
      total++; if (ns != exp_stall) begin bad++; $display("FAIL rnd%0d_stall got=%0d want=%0d", t, ns, exp_stall); end
      total++; if (nr != (ld ? exp_issue : 0)) begin bad++; $display("FAIL rnd%0d_rd got=%0d want=%0d", t, nr, ld ? exp_issue : 0); end
      total++; if (nw != (ld ? 0 : exp_issue)) begin bad++; $display("FAIL rnd%0d_wr got=%0d want=%0d", t, nw, ld ? 0 : exp_issue); end
      total++; if (v !== exp_v) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", t, v, exp_v); end
      total++; if (o !== exp_o) begin bad++; $display("FAIL rnd%0d_memout got=%h want=%h", t, o, exp_o); end
      total++; if (np != 0) begin bad++; $display("FAIL rnd%0d_proto got=%0d bad cycles want=0", t, np); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd%0d_err got=%b want=0", t, err); end
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        mif.mem_done = 1'($urandom);
        mif.mem_data_out = DW'($urandom);
        flush = 1'($urandom);
        @(negedge clk);
        total++; if (Stall !== 1'b0 || MemValid !== 1'b0 || MemOut !== '0) begin
          bad++; $display("FAIL rnd%0d_gap got stall=%b valid=%b out=%h want 0/0/0000", t, Stall, MemValid, MemOut);
        end
        step();
        idle_inputs();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_hit_load();
    test_miss_store();
    test_busy_retry();
    test_flush_mid_miss();
    test_idle_ignore();
    test_bad_request();
    test_mem_err();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
